// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types for the AES inverse SubBytes stage
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/aes_inv_subbytes_if.sv
// rtl/aes_inv_subbytes_if.sv - handshake bundle for the inverse SubBytes stage
interface aes_inv_subbytes_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t block_in;
  block_t round_key;
  logic   out_valid;
  logic   out_ready;
  block_t block_out;
  logic   busy;

  modport master (
    output in_valid, block_in, round_key, out_ready,
    input  in_ready, out_valid, block_out, busy
  );

  modport slave (
    input  in_valid, block_in, round_key, out_ready,
    output in_ready, out_valid, block_out, busy
  );

endinterface

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational FIPS-197 inverse S-box, one byte
module aes_inv_sbox
  import aes_pkg::*;
(
  input  byte_t byte_i,
  output byte_t byte_o
);

  // Row r of the table holds entries 16r..16r+15; entry 0 sits in the top byte.
  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry x lives at bit offset 8*(255-x), i.e. {~x, 3'b000}.
  logic [10:0] bit_idx;
  assign bit_idx = {~byte_i, 3'b000};
  assign byte_o  = INV_TABLE[bit_idx +: 8];

endmodule

// File: rtl/aes_inv_subbytes.sv
// rtl/aes_inv_subbytes.sv - chunked InvSubBytes stage; AES_INV_ADDKEY_EN fuses AddRoundKey
module aes_inv_subbytes
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  block_t block_in,
  input  block_t round_key,
  output logic   out_valid,
  input  logic   out_ready,
  output block_t block_out,
  output logic   busy
);

  localparam int CHUNKS = 16 / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  block_t           work_q, work_d;
  logic [LANES*8-1:0] sub_bytes;

  // One inverse S-box per lane, fed from the chunk selected by the counter.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    byte_t sb_in;
    byte_t sb_out;
    assign sb_in = work_q[(int'(cnt_q) * LANES + l) * 8 +: 8];
    aes_inv_sbox u_sbox (.byte_i(sb_in), .byte_o(sb_out));
    assign sub_bytes[8*l +: 8] = sb_out;
  end

  // Next-state logic: accept in IDLE, substitute one chunk per SUB cycle, park in HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = block_in;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        work_d[int'(cnt_q) * LANES * 8 +: LANES * 8] = sub_bytes;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and working block registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);

`ifdef AES_INV_ADDKEY_EN
  block_t key_q;

  // Round key is captured alongside the block on the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (in_ready && in_valid) begin
      key_q <= round_key;
    end
  end

  assign block_out = out_valid ? (work_q ^ key_q) : work_q;
`else
  logic unused_round_key;
  assign unused_round_key = ^round_key;
  assign block_out = work_q;
`endif

endmodule
